spi_reg_slave: RTL

- Parametrised SPI-slave register file; successor to the Nexys4 display SPI receiver.
- Adds generic word width, register count, readback on MISO, burst auto-increment, and frame abort on slave-select deassert.
- Entirely in the spi_sclk_i domain. Register contents and a write-toggle are exported for downstream consumers (display driver, CDC synchroniser).

---
 rtl/spi_reg_pkg.sv | 20 ++
 rtl/spi_frame_counter.sv | 60 ++++++
 rtl/spi_reg_slave.sv | 134 +++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared command codes, phase encoding and address wrap for spi_reg_slave
package spi_reg_pkg;

  localparam int unsigned CMD_WRITE       = 1;
  localparam int unsigned CMD_READ        = 2;
  localparam int unsigned CMD_WRITE_BURST = 3;
  localparam int unsigned CMD_READ_BURST  = 4;

  typedef enum logic [1:0] {
    PH_HEADER = 2'd0,
    PH_DATA   = 2'd1,
    PH_IGNORE = 2'd2
  } phase_e;

  // Burst address step: the last register (or anything beyond it) wraps to 0.
  function automatic int unsigned next_addr(input int unsigned addr, input int unsigned num_regs);
    return (addr + 1 >= num_regs) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/spi_frame_counter.sv
// rtl/spi_frame_counter.sv - header/data bit counting and frame phase FSM, cleared per frame
module spi_frame_counter
  import spi_reg_pkg::*;
#(
  parameter int HDR_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic   i_clk,
  input  logic   i_frame_rst_n,
  input  logic   i_known_cmd,
  input  logic   i_single,
  output logic   o_hdr_done,
  output logic   o_word_done,
  output phase_e o_phase
);

  localparam int HC_W = (HDR_W > 1) ? $clog2(HDR_W) : 1;
  localparam int DC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [HC_W-1:0] HDR_LAST = HC_W'(HDR_W - 1);
  localparam logic [DC_W-1:0] BIT_LAST = DC_W'(DATA_W - 1);

  logic [HC_W-1:0] r_hdr_cnt;
  logic [DC_W-1:0] r_bit_cnt;
  phase_e          r_phase;

  assign o_hdr_done  = (r_phase == PH_HEADER) && (r_hdr_cnt == HDR_LAST);
  assign o_word_done = (r_phase == PH_DATA) && (r_bit_cnt == BIT_LAST);
  assign o_phase     = r_phase;

  always_ff @(posedge i_clk or negedge i_frame_rst_n) begin
    if (!i_frame_rst_n) begin
      r_hdr_cnt <= '0;
      r_bit_cnt <= '0;
      r_phase   <= PH_HEADER;
    end else begin
      case (r_phase)
        PH_HEADER: begin
          if (r_hdr_cnt == HDR_LAST) begin
            r_phase <= i_known_cmd ? PH_DATA : PH_IGNORE;
          end else begin
            r_hdr_cnt <= r_hdr_cnt + 1'b1;
          end
        end
        PH_DATA: begin
          // Wraps per word so arbitrarily long bursts never overflow.
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= '0;
            if (i_single) begin
              r_phase <= PH_IGNORE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: r_phase <= PH_IGNORE;
      endcase
    end
  end

endmodule

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI-slave register file with readback, burst auto-increment and frame abort
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              NUM_REGS  = 10,
  parameter int              ADDR_W    = 4,
  parameter int              CMD_W     = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       spi_sclk_i,
  input  logic                       rst_low_i,
  input  logic                       spi_ss_i,
  input  logic                       spi_mosi_i,
  output logic                       spi_miso_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic                       wr_toggle_o
);

  localparam int HDR_W = CMD_W + ADDR_W;
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  logic [HDR_W-2:0]  r_hdr;
  logic [CMD_W-1:0]  r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-2:0] r_data;
  logic [DATA_W-1:0] r_rd_sr;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_wr_toggle;

  logic [HDR_W-1:0]  w_hdr_next;
  logic [CMD_W-1:0]  w_cmd_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [DATA_W-1:0] w_word;
  logic              w_frame_rst_n;
  logic              w_known, w_single, w_is_write, w_is_read, w_is_burst;
  logic              w_hdr_done, w_word_done;
  phase_e            w_phase;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NUM_REGS_L;
  endfunction

  function automatic logic [DATA_W-1:0] reg_or_ones(input logic [ADDR_W-1:0] a);
    return in_range(a) ? r_regs[a] : '1;
  endfunction

  assign w_hdr_next  = {r_hdr, spi_mosi_i};
  assign w_cmd_next  = w_hdr_next[HDR_W-1 -: CMD_W];
  assign w_addr_next = w_hdr_next[ADDR_W-1:0];
  assign w_word      = {r_data, spi_mosi_i};
  assign w_addr_inc  = ADDR_W'(next_addr(32'(r_addr), NUM_REGS));

  assign w_known    = (w_cmd_next == CMD_W'(CMD_WRITE)) || (w_cmd_next == CMD_W'(CMD_READ)) ||
                      (w_cmd_next == CMD_W'(CMD_WRITE_BURST)) || (w_cmd_next == CMD_W'(CMD_READ_BURST));
  assign w_single   = (r_cmd == CMD_W'(CMD_WRITE)) || (r_cmd == CMD_W'(CMD_READ));
  assign w_is_write = (r_cmd == CMD_W'(CMD_WRITE)) || (r_cmd == CMD_W'(CMD_WRITE_BURST));
  assign w_is_read  = (r_cmd == CMD_W'(CMD_READ)) || (r_cmd == CMD_W'(CMD_READ_BURST));
  assign w_is_burst = (r_cmd == CMD_W'(CMD_WRITE_BURST)) || (r_cmd == CMD_W'(CMD_READ_BURST));

  // Frame state is wiped by either reset or slave-select going high.
  assign w_frame_rst_n = rst_low_i & ~spi_ss_i;

  spi_frame_counter #(
    .HDR_W  (HDR_W),
    .DATA_W (DATA_W)
  ) u_frame_counter (
    .i_clk         (spi_sclk_i),
    .i_frame_rst_n (w_frame_rst_n),
    .i_known_cmd   (w_known),
    .i_single      (w_single),
    .o_hdr_done    (w_hdr_done),
    .o_word_done   (w_word_done),
    .o_phase       (w_phase)
  );

  always_ff @(posedge spi_sclk_i or negedge w_frame_rst_n) begin
    if (!w_frame_rst_n) begin
      r_hdr   <= '0;
      r_cmd   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rd_sr <= '1;
    end else begin
      case (w_phase)
        PH_HEADER: begin
          r_hdr <= w_hdr_next[HDR_W-2:0];
          if (w_hdr_done) begin
            r_cmd   <= w_cmd_next;
            r_addr  <= w_addr_next;
            r_rd_sr <= reg_or_ones(w_addr_next);
          end
        end
        PH_DATA: begin
          r_data <= w_word[DATA_W-2:0];
          if (w_word_done && w_is_burst) begin
            r_addr  <= w_addr_inc;
            r_rd_sr <= reg_or_ones(w_addr_inc);
          end else begin
            r_rd_sr <= {r_rd_sr[DATA_W-2:0], 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge spi_sclk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= RESET_VAL;
      end
      r_wr_addr   <= '0;
      r_wr_toggle <= 1'b0;
    end else if (w_word_done && w_is_write && in_range(r_addr)) begin
      r_regs[r_addr] <= w_word;
      r_wr_addr      <= r_addr;
      r_wr_toggle    <= ~r_wr_toggle;
    end
  end

  assign spi_miso_o = (spi_ss_i || (w_phase != PH_DATA) || !w_is_read) ? 1'b1 : r_rd_sr[DATA_W-1];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_o[k*DATA_W +: DATA_W] = r_regs[k];
  end

  assign wr_addr_o   = r_wr_addr;
  assign wr_toggle_o = r_wr_toggle;

endmodule
